// File: rtl/cpu_cmd_sequencer_pkg.sv
// Shared types and default parameters for the CPU command sequencer.
// Imported by the interface, the command FIFO and the sequencer top.
package cpu_cmd_sequencer_pkg;

    localparam int WIDTH_DEF    = 8;
    localparam int CMD_W_DEF    = 7;
    localparam int DEPTH_DEF    = 4;
    localparam int LATENCY_DEF  = 4;
    localparam int IDLE_CMD_DEF = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } seq_state_t;

    typedef logic [CMD_W_DEF-1:0] cmd_t;

    // Width of a down-counter that must hold values 0..lat.
    function automatic int cnt_w(input int lat);
        return (lat < 1) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/cpu_cmd_sequencer_if.sv
// Host-side channels of the sequencer: command in, result out.
// The host drives the master side, the sequencer implements the slave side.
interface cpu_cmd_sequencer_if
    import cpu_cmd_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CMD_W = CMD_W_DEF
);

    logic               s_valid;
    logic               s_ready;
    logic [CMD_W-1:0]   s_cmd;
    logic [WIDTH-1:0]   s_d1;
    logic [WIDTH-1:0]   s_d2;
    logic [WIDTH-1:0]   s_d3;

    logic               r_valid;
    logic               r_ready;
    logic [2*WIDTH-1:0] r_data;
    logic               r_zero;
    logic               r_error;

    modport master (
        output s_valid, s_cmd, s_d1, s_d2, s_d3, r_ready,
        input  s_ready, r_valid, r_data, r_zero, r_error
    );

    modport slave (
        input  s_valid, s_cmd, s_d1, s_d2, s_d3, r_ready,
        output s_ready, r_valid, r_data, r_zero, r_error
    );

endinterface

// File: rtl/cpu_cmd_sequencer_fifo.sv
// Synchronous command FIFO, no write-to-read bypass.
// Full/empty are derived from an occupancy count one bit wider than the pointers.
module cpu_cmd_sequencer_fifo
    import cpu_cmd_sequencer_pkg::*;
#(
    parameter int W     = CMD_W_DEF + 3 * WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // Storage write; contents need no reset since count guards reads.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

    // Pointers wrap naturally modulo the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpu_cmd_sequencer.sv
// Presents queued host commands to the CPU one at a time, holds the bus
// for a fixed window, then captures the CPU result for the host.
module cpu_cmd_sequencer
    import cpu_cmd_sequencer_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter int               CMD_W    = CMD_W_DEF,
    parameter int               DEPTH    = DEPTH_DEF,
    parameter int               LATENCY  = LATENCY_DEF,
    parameter logic [CMD_W-1:0] IDLE_CMD = CMD_W'(IDLE_CMD_DEF)
) (
    input  logic                clk,
    input  logic                rst,
    cpu_cmd_sequencer_if.slave  host,
    output logic [CMD_W-1:0]    cmdin,
    output logic [WIDTH-1:0]    din_1,
    output logic [WIDTH-1:0]    din_2,
    output logic [WIDTH-1:0]    din_3,
    input  logic [WIDTH-1:0]    dout_high,
    input  logic [WIDTH-1:0]    dout_low,
    input  logic                zero,
    input  logic                error,
    output logic                busy
);

    localparam int FW = CMD_W + 3 * WIDTH;
    localparam int CW = cnt_w(LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    logic [FW-1:0] wdata;
    logic [FW-1:0] rdata;
    logic          full;
    logic          empty;
    logic          pop;
    seq_state_t    state;
    logic [CW-1:0] cnt;

    assign wdata        = {host.s_cmd, host.s_d1, host.s_d2, host.s_d3};
    assign host.s_ready = !full;
    assign pop          = (state == IDLE) && !empty;
    assign busy         = (state != IDLE) || !empty;

    cpu_cmd_sequencer_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (host.s_valid),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    // Issue / hold / capture FSM with registered CPU bus and result.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            cmdin        <= IDLE_CMD;
            din_1        <= '0;
            din_2        <= '0;
            din_3        <= '0;
            host.r_valid <= 1'b0;
            host.r_data  <= '0;
            host.r_zero  <= 1'b0;
            host.r_error <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        {cmdin, din_1, din_2, din_3} <= rdata;
                        cnt   <= CNT_LOAD;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == CNT_LAST) begin
                        host.r_data  <= {dout_high, dout_low};
                        host.r_zero  <= zero;
                        host.r_error <= error;
                        host.r_valid <= 1'b1;
                        cmdin        <= IDLE_CMD;
                        din_1        <= '0;
                        din_2        <= '0;
                        din_3        <= '0;
                        state        <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (host.r_ready) begin
                        host.r_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
